dram_word_responder: RTL and testbench



---
 rtl/dram_if_pkg.sv | 10 +
 rtl/dram_word_responder_if.sv | 16 +
 rtl/dram_word_bram.sv | 18 +
 rtl/dram_word_responder.sv | 101 ++++++++++
 tb/tb_dram_word_responder.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/dram_if_pkg.sv
// dram_if_pkg: shared state/op encodings and mask constants for the word-level DRAM responder
package dram_if_pkg;
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_BUSY, ST_DONE} state_t;
    typedef enum logic [1:0] {OP_WR, OP_RA, OP_RB, OP_RF} op_t;
    localparam logic [3:0] MASK_ALL_OFF = 4'hF;
    // request vector bit order is {refresh, read_b, read_a, write}, matching op_t
    function automatic logic [3:0] op_bit(op_t op);
        return 4'b0001 << op;
    endfunction
endpackage

// File: rtl/dram_word_responder_if.sv
// dram_word_responder_if: word-level SDRAM controller bus between the load/store front end and the memory
interface dram_word_responder_if;
    logic        read_a, read_b, write, refresh;
    logic [31:0] addr, din;
    logic [3:0]  mask;
    logic [31:0] dout_a, dout_b, total_written;
    logic        busy, mem_initialized, fail;
    modport master(
        output read_a, read_b, write, refresh, addr, din, mask,
        input  dout_a, dout_b, busy, mem_initialized, fail, total_written
    );
    modport slave(
        input  read_a, read_b, write, refresh, addr, din, mask,
        output dout_a, dout_b, busy, mem_initialized, fail, total_written
    );
endinterface

// File: rtl/dram_word_bram.sv
// dram_word_bram: single-port 32-bit RAM with byte write enables and registered read
module dram_word_bram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        rdata <= mem[addr];
    end
endmodule

// File: rtl/dram_word_responder.sv
// dram_word_responder: BRAM-backed stand-in for the word-level SDRAM controller with exact busy handshake
module dram_word_responder
    import dram_if_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int READ_LAT    = 4,
    parameter int WRITE_LAT   = 3,
    parameter int REFRESH_LAT = 6,
    parameter int INIT_CLEAR  = 1,
    parameter int INIT_WAIT   = 16
) (
    input logic clk,
    input logic rst_x,
    dram_word_responder_if.slave bus
);
    localparam int INIT_N = INIT_CLEAR != 0 ? 2**ADDR_W : INIT_WAIT;

    state_t            state;
    op_t               op, req_op;
    logic [3:0]        req, cnt, wmask, ram_be;
    logic [31:0]       init_cnt, wdin, ram_wdata, rdata;
    logic [ADDR_W-1:0] waddr, ram_addr;
    logic              ram_we, unused_addr;

    function automatic logic [3:0] lat_m1(op_t o);
        return o == OP_WR ? 4'(WRITE_LAT - 1) : o == OP_RF ? 4'(REFRESH_LAT - 1) : 4'(READ_LAT - 1);
    endfunction

    assign req         = {bus.refresh, bus.read_b, bus.read_a, bus.write};
    assign req_op      = req[0] ? OP_WR : req[1] ? OP_RA : req[2] ? OP_RB : OP_RF;
    assign unused_addr = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};

    // the RAM reads the live address in IDLE so a 1-cycle read has its data ready at completion
    always_comb begin
        ram_we    = rst_x && (state == ST_INIT ? INIT_CLEAR != 0
                                               : state == ST_BUSY && op == OP_WR && cnt == lat_m1(OP_WR));
        ram_be    = state == ST_INIT ? MASK_ALL_OFF : ~wmask;
        ram_addr  = state == ST_INIT ? init_cnt[ADDR_W-1:0] : state == ST_IDLE ? bus.addr[ADDR_W+1:2] : waddr;
        ram_wdata = state == ST_INIT ? '0 : wdin;
    end

    dram_word_bram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_x) begin
            state                <= ST_INIT;
            op                   <= OP_WR;
            cnt                  <= '0;
            init_cnt             <= '0;
            waddr                <= '0;
            wdin                 <= '0;
            wmask                <= MASK_ALL_OFF;
            bus.busy             <= 1'b1;
            bus.mem_initialized  <= 1'b0;
            bus.fail             <= 1'b0;
            bus.dout_a           <= '0;
            bus.dout_b           <= '0;
            bus.total_written    <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == 32'(INIT_N - 1)) begin
                        bus.busy            <= 1'b0;
                        bus.mem_initialized <= 1'b1;
                        state               <= ST_IDLE;
                    end else init_cnt <= init_cnt + 1;
                end
                ST_IDLE: begin
                    if (|req) begin
                        op       <= req_op;
                        waddr    <= bus.addr[ADDR_W+1:2];
                        wdin     <= bus.din;
                        wmask    <= bus.mask;
                        cnt      <= lat_m1(req_op);
                        bus.busy <= 1'b1;
                        state    <= ST_BUSY;
                        if ($countones(req) > 1) bus.fail <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (|(req & ~op_bit(op))) bus.fail <= 1'b1;
                    if (cnt == '0) begin
                        bus.busy <= 1'b0;
                        state    <= ST_DONE;
                        if (op == OP_WR) bus.total_written <= bus.total_written + 1;
                        if (op == OP_RA) bus.dout_a <= rdata;
                        if (op == OP_RB) bus.dout_b <= rdata;
                    end else cnt <= cnt - 1;
                end
                ST_DONE: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_word_responder.sv
// tb_dram_word_responder: directed checks of the responder against a transaction-level memory model
module tb_dram_word_responder;
    localparam int RL = 4, WL = 3, FL = 6;

    logic clk = 1'b0;
    logic rst_x = 1'b0;
    always #5 clk = ~clk;

    dram_word_responder_if bus();

    dram_word_responder #(
        .ADDR_W(4), .READ_LAT(RL), .WRITE_LAT(WL), .REFRESH_LAT(FL), .INIT_CLEAR(1), .INIT_WAIT(16)
    ) dut (
        .clk   (clk),
        .rst_x (rst_x),
        .bus   (bus)
    );

    logic [31:0] m_mem [16];
    logic [31:0] m_da, m_db, m_tw;
    logic        m_fail, m_init;
    bit          chk_en = 0;
    int          errs = 0, checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] v);
        {bus.refresh, bus.read_b, bus.read_a, bus.write} = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_da = '0; m_db = '0; m_tw = '0; m_fail = 1'b0; m_init = 1'b0;
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("dout_a", bus.dout_a, m_da);
        chk("dout_b", bus.dout_b, m_db);
        chk("total_written", bus.total_written, m_tw);
        chk("fail", {31'd0, bus.fail}, {31'd0, m_fail});
        chk("mem_initialized", {31'd0, bus.mem_initialized}, {31'd0, m_init});
    end

    task automatic init_wait();
        int n = 1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (!bus.busy) break;
            n++;
        end
        m_init = 1'b1;
        chk("init_cycles", n, 16);
        chk("init_done", {31'd0, bus.mem_initialized}, 32'd1);
    endtask

    // r: request lines held for the whole access; extra: lines pulsed on the first busy edge
    task automatic req(input logic [3:0] r, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [3:0] extra, input int exp_wait);
        int w, n, lat;
        logic [3:0] sel, wi;
        sel = r[0] ? 4'b0001 : r[1] ? 4'b0010 : r[2] ? 4'b0100 : 4'b1000;
        lat = sel[0] ? WL : sel[3] ? FL : RL;
        wi  = a[5:2];
        @(negedge clk);
        drive(r); bus.addr = a; bus.din = d; bus.mask = m;
        for (w = 1; w <= 10; w++) begin
            @(posedge clk); #1;
            if (bus.busy) break;
        end
        chk("accept_wait", w, exp_wait);
        if (w > 10) begin
            drive('0);
            return;
        end
        if ($countones(r) > 1) m_fail = 1'b1;
        @(negedge clk);
        drive(r | extra);
        n = 1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (k == 0 && (extra & ~sel) != 0) m_fail = 1'b1;
            drive(r);
            if (!bus.busy) break;
            n++;
        end
        if (sel[0]) begin
            for (int i = 0; i < 4; i++) if (!m[i]) m_mem[wi][8*i +: 8] = d[8*i +: 8];
            m_tw++;
        end else if (sel[1]) m_da = m_mem[wi];
        else if (sel[2]) m_db = m_mem[wi];
        drive('0);
        chk("busy_cycles", n, lat);
    endtask

    initial begin
        int w;
        drive('0); bus.addr = '0; bus.din = '0; bus.mask = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        chk_en = 1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk); rst_x = 1'b1;
        init_wait();

        req(4'b0010, 32'h3C, 0, 4'hF, 0, 1);
        chk("cleared_word", bus.dout_a, 32'h0);
        req(4'b0001, 32'h10, 32'hDEADBEEF, 4'h0, 0, 2);
        req(4'b0010, 32'h10, 0, 4'hF, 0, 2);
        chk("raw_read", bus.dout_a, 32'hDEADBEEF);
        chk("tw_one", bus.total_written, 32'd1);

        req(4'b0001, 32'h20, 32'h11223344, 4'h0, 0, 2);
        req(4'b0001, 32'h24, 32'h55667788, 4'h0, 0, 2);
        req(4'b0001, 32'h20, 32'h0000AA00, 4'hD, 0, 2);
        req(4'b0001, 32'h24, 32'h000000BB, 4'hE, 0, 2);
        req(4'b0010, 32'h20, 0, 4'hF, 0, 2);
        chk("split_lo", bus.dout_a, 32'h1122AA44);
        req(4'b0100, 32'h24, 0, 4'hF, 0, 2);
        chk("split_hi", bus.dout_b, 32'h556677BB);

        req(4'b0010, 32'h14, 0, 4'hF, 0, 2);
        req(4'b0100, 32'h50, 0, 4'hF, 0, 2);
        chk("alias_b", bus.dout_b, 32'hDEADBEEF);
        chk("a_kept", bus.dout_a, 32'h0);

        req(4'b0001, 32'h14, 32'hFFFFFFFF, 4'hF, 0, 2);
        req(4'b0010, 32'h17, 0, 4'hF, 0, 2);
        chk("noop_write", bus.dout_a, 32'h0);
        chk("tw_six", bus.total_written, 32'd6);
        req(4'b1000, 32'h0, 0, 4'hF, 0, 2);

        req(4'b0011, 32'h30, 32'hCAFEF00D, 4'h0, 0, 2);
        chk("prio_fail", {31'd0, bus.fail}, 32'd1);
        req(4'b0010, 32'h30, 0, 4'hF, 0, 2);
        chk("prio_write", bus.dout_a, 32'hCAFEF00D);
        chk("fail_sticky", {31'd0, bus.fail}, 32'd1);

        req(4'b1000, 32'h0, 0, 4'hF, 0, 2);
        @(negedge clk);
        drive(4'b0001); bus.addr = 32'h10; bus.din = 32'hFFFFFFFF; bus.mask = 4'h0;
        for (w = 1; w <= 10; w++) begin
            @(posedge clk); #1;
            if (bus.busy) break;
        end
        chk("rst_wr_accept", w, 2);
        @(negedge clk); rst_x = 1'b0; drive('0);
        @(posedge clk); #1;
        model_reset();
        chk("rerst_busy", {31'd0, bus.busy}, 32'd1);
        chk("rerst_init", {31'd0, bus.mem_initialized}, 32'd0);
        @(negedge clk); rst_x = 1'b1;
        init_wait();
        chk("fail_cleared", {31'd0, bus.fail}, 32'd0);
        req(4'b0010, 32'h10, 0, 4'hF, 0, 1);
        chk("aborted_write", bus.dout_a, 32'h0);

        req(4'b0001, 32'h08, 32'h12345678, 4'h0, 4'b0100, 2);
        chk("foreign_fail", {31'd0, bus.fail}, 32'd1);
        req(4'b0010, 32'h08, 0, 4'hF, 0, 2);
        chk("after_foreign", bus.dout_a, 32'h12345678);

        @(negedge clk);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
